// File: rtl/data_sram_like_responder_pkg.sv
// rtl/data_sram_like_responder_pkg.sv - shared encodings and entry sizing for the sram-like data responder
package data_sram_like_responder_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Down-counter width; LATENCY-1 must fit, and a 1-cycle latency still needs one bit.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

    // Queue entry = {is_wr, rdata[31:0], cnt}.
    function automatic int resp_w(input int cnt_w);
        return 1 + 32 + cnt_w;
    endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// rtl/sram_like_resp_fifo.sv - in-order response queue with per-entry latency down-counters
module sram_like_resp_fifo
    import data_sram_like_responder_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  logic        push_is_wr,
    input  logic [31:0] push_rdata,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output logic        head_ready,
    output logic        head_is_wr,
    output logic [31:0] head_rdata
);

    localparam int CNT_W  = cnt_width(LATENCY);
    localparam int RESP_W = resp_w(CNT_W);
    localparam int PW     = $clog2(DEPTH);

    logic [RESP_W-1:0] ent_q [DEPTH];
    logic [RESP_W-1:0] ent_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic [RESP_W-1:0] head;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i][CNT_W-1:0] != '0) begin
                ent_d[i][CNT_W-1:0] = ent_q[i][CNT_W-1:0] - CNT_W'(1);
            end
        end
        if (push) begin
            ent_d[wr_ptr_q] = {push_is_wr, push_rdata, CNT_W'(LATENCY - 1)};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign head       = ent_q[rd_ptr_q];
    assign full       = (count_q == (PW+1)'(DEPTH));
    assign empty      = (count_q == '0);
    assign head_ready = !empty && (head[CNT_W-1:0] == '0);
    assign head_is_wr = head[RESP_W-1];
    assign head_rdata = head[CNT_W +: 32];

endmodule

// File: rtl/data_sram_like_responder.sv
// rtl/data_sram_like_responder.sv - sram-like data responder backed by a word-addressed on-chip RAM
module data_sram_like_responder
    import data_sram_like_responder_pkg::*;
#(
    parameter int AW      = 10,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        addr_stall,
    input  logic        sram_req,
    input  logic        sram_wr,
    input  logic [1:0]  sram_size,
    input  logic [3:0]  sram_wstrb,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic        sram_addr_ok,
    output logic        sram_data_ok,
    output logic [31:0] sram_rdata
);

    logic [31:0]   ram_q [2**AW];
    logic [AW-1:0] word_idx;
    logic          accept;
    logic          full;
    logic          empty;
    logic          head_ready;
    logic          head_is_wr;
    logic [31:0]   head_rdata;
    logic [31:0]   push_rdata;
    logic          unused_ok;

    // Size and sub-word address bits do not steer anything: wstrb and the word index do.
    assign unused_ok = ^{sram_size, sram_addr[31:AW+2], sram_addr[1:0], empty};

    assign word_idx     = sram_addr[AW+1:2];
    assign sram_addr_ok = resetn && !full && !addr_stall;
    assign accept       = sram_req && sram_addr_ok;

    // Read data is captured from the pre-edge RAM word, so a same-edge write cannot leak in.
    assign push_rdata = sram_wr ? 32'h0 : ram_q[word_idx];

    always_ff @(posedge clk) begin
        if (accept && sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_wstrb[i]) begin
                    ram_q[word_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
                end
            end
        end
    end

    sram_like_resp_fifo #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_is_wr (sram_wr),
        .push_rdata (push_rdata),
        .pop        (head_ready),
        .full       (full),
        .empty      (empty),
        .head_ready (head_ready),
        .head_is_wr (head_is_wr),
        .head_rdata (head_rdata)
    );

    assign sram_data_ok = head_ready;
    assign sram_rdata   = (head_ready && !head_is_wr) ? head_rdata : 32'h0;

endmodule

// File: tb/tb_data_sram_like_responder.sv
// tb/tb_data_sram_like_responder.sv - directed and randomized checks of data_sram_like_responder against a reference model
module tb_data_sram_like_responder;

    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int LAT   = 4;
    localparam int WORDS = 2**AW;

    logic        clk = 1'b0;
    logic        resetn;
    logic        addr_stall;
    logic        sram_req;
    logic        sram_wr;
    logic [1:0]  sram_size;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_addr_ok;
    logic        sram_data_ok;
    logic [31:0] sram_rdata;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q [$];
    logic [31:0] mmem [WORDS];
    int          cyc;
    int          vectors;
    int          miscompares;

    always #5 clk = ~clk;

    data_sram_like_responder #(
        .AW      (AW),
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .addr_stall   (addr_stall),
        .sram_req     (sram_req),
        .sram_wr      (sram_wr),
        .sram_size    (sram_size),
        .sram_wstrb   (sram_wstrb),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_addr_ok (sram_addr_ok),
        .sram_data_ok (sram_data_ok),
        .sram_rdata   (sram_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, advance the model, clock.
    task automatic step(input logic req, input logic wr, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic stall, output logic acc);
        logic        exp_ok;
        logic        exp_dok;
        logic [31:0] exp_rd;
        int          idx;
        resp_t       e;
        sram_req   = req;
        sram_wr    = wr;
        sram_wstrb = strb;
        sram_addr  = addr;
        sram_wdata = wdata;
        sram_size  = 2'd2;
        addr_stall = stall;
        @(negedge clk);
        exp_ok  = !stall && (exp_q.size() < DEPTH);
        exp_dok = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        exp_rd  = exp_dok ? exp_q[0].data : 32'h0;
        check("addr_ok", {31'h0, sram_addr_ok}, {31'h0, exp_ok});
        check("data_ok", {31'h0, sram_data_ok}, {31'h0, exp_dok});
        check("rdata", sram_rdata, exp_rd);
        if (exp_dok) void'(exp_q.pop_front());
        acc = req && exp_ok;
        if (acc) begin
            idx   = int'((addr / 4) % WORDS);
            e.due = cyc + LAT;
            e.data = wr ? 32'h0 : mmem[idx];
            exp_q.push_back(e);
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) mmem[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, acc);
    endtask

    task automatic do_reset();
        sram_req = 1'b0;
        resetn   = 1'b0;
        #1;
        check("rst_addr_ok", {31'h0, sram_addr_ok}, 32'h0);
        check("rst_data_ok", {31'h0, sram_data_ok}, 32'h0);
        check("rst_rdata", sram_rdata, 32'h0);
        exp_q.delete();
        @(posedge clk);
        cyc++;
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        logic        acc;
        int          n_acc;
        logic [31:0] a;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        resetn      = 1'b0;
        addr_stall  = 1'b0;
        sram_req    = 1'b0;
        sram_wr     = 1'b0;
        sram_size   = 2'd0;
        sram_wstrb  = 4'h0;
        sram_addr   = 32'h0;
        sram_wdata  = 32'h0;
        for (int i = 0; i < WORDS; i++) mmem[i] = 32'h0;
        #2;
        check("reset_addr_ok", {31'h0, sram_addr_ok}, 32'h0);
        check("reset_data_ok", {31'h0, sram_data_ok}, 32'h0);
        check("reset_rdata", sram_rdata, 32'h0);
        @(posedge clk);
        cyc++;
        #1;
        resetn = 1'b1;

        // Full-word store then read-back.
        step(1'b1, 1'b1, 4'hF, 32'h100, 32'h11223344, 1'b0, acc);
        step(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, acc);
        idle(LAT + 2);
        // Byte store into lane 2, then read.
        step(1'b1, 1'b1, 4'b0100, 32'h102, 32'hAAAAAAAA, 1'b0, acc);
        step(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, acc);
        idle(LAT + 2);
        // Cancelled store still responds and leaves the word alone.
        step(1'b1, 1'b1, 4'h0, 32'h100, 32'hFFFFFFFF, 1'b0, acc);
        step(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, acc);
        idle(LAT + 2);
        // Prime a few neighbouring words for the held-request burst.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 4'hF, 32'h104 + 32'(4*i), 32'hC0DE0000 + 32'(i), 1'b0, acc);
        end
        idle(LAT + 2);
        // Six reads with req held: queue fills and addr_ok throttles.
        n_acc = 0;
        for (int k = 0; k < 40 && n_acc < 6; k++) begin
            step(1'b1, 1'b0, 4'h0, 32'h104 + 32'(4*n_acc), 32'h0, 1'b0, acc);
            if (acc) n_acc++;
        end
        idle(LAT + 2);
        // Stall for three cycles with a pending store, then release.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b1, acc);
        step(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, acc);
        step(1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b0, acc);
        step(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, acc);
        idle(LAT + 2);
        // Reset with three outstanding reads, then check aliasing of upper address bits.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, acc);
        do_reset();
        idle(LAT + 2);
        step(1'b1, 1'b1, 4'hF, 32'h1000_0100, 32'h5A5AA5A5, 1'b0, acc);
        step(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, acc);
        idle(LAT + 2);

        // Randomized traffic over a small window of words with aliased upper bits.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 4'hF, 32'h100 + 32'(4*i), $urandom, 1'b0, acc);
        end
        for (int k = 0; k < 400; k++) begin
            a = {$urandom_range(0, 1048575) & 32'hFFFFF, 12'h0} | (32'h100 + 32'(4*$urandom_range(0, 15)))
                | 32'($urandom_range(0, 3));
            step(($urandom % 4) != 0, ($urandom % 2) == 0, 4'($urandom), a, $urandom,
                 ($urandom % 5) == 0, acc);
            if (k == 200) do_reset();
        end
        idle(LAT + 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
